crc32_slice4_engine: RTL

Pipelined slicing-by-4 CRC-32 engine: the stage directly upstream of the CRC lookup-table ROMs. It accepts a framed stream of 32-bit words, drives the read addresses of four combinational 256x32 table ROMs, XOR-folds their read data into a running CRC register, and emits the final CRC per frame. Partial last words (1-3 bytes) are finished with a byte-serial tail loop on table 0. CRC is reflected CRC-32: poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.

---
 rtl/crc32_slice4_engine.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/crc32_slice4_engine.sv
// Slicing-by-4 reflected CRC-32 engine feeding four external combinational
// 256x32 table ROMs. Full words fold in one cycle; a 1-3 byte final word is
// finished byte-serially on table 0 while in_ready is held low.
module crc32_slice4_engine #(
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [2:0]  in_nbytes,
  output logic [31:0] tab0_addr,
  output logic [31:0] tab1_addr,
  output logic [31:0] tab2_addr,
  output logic [31:0] tab3_addr,
  input  logic [31:0] tab0_rdata,
  input  logic [31:0] tab1_rdata,
  input  logic [31:0] tab2_rdata,
  input  logic [31:0] tab3_rdata,
  output logic        crc_valid,
  output logic [31:0] crc_out
);

  localparam int unsigned CRC_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TAIL_W = 24;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned PAD_W  = CRC_W - BYTE_W;

  typedef enum logic {
    RUN  = 1'b0,
    TAIL = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [CRC_W-1:0]    crc_reg, crc_d;
  logic [TAIL_W-1:0]   tail_data, tail_data_d;
  logic [CNT_W-1:0]    tail_cnt, tail_cnt_d;
  logic                crc_valid_d;
  logic [CRC_W-1:0]    crc_out_d;

  logic                accept;
  logic                partial_eop;
  logic [CRC_W-1:0]    base;
  logic [CRC_W-1:0]    word_x;
  logic [CRC_W-1:0]    word_fold;
  logic [BYTE_W-1:0]   tail_idx;
  logic [CRC_W-1:0]    tail_fold;

  // Handshake: the engine only stalls while draining a partial last word
  assign in_ready = (state == RUN);
  assign accept   = in_valid & in_ready;

  // Datapath terms shared by the word step and the byte-serial tail step
  assign partial_eop = (in_nbytes == 3'd1) || (in_nbytes == 3'd2) || (in_nbytes == 3'd3);
  assign base        = in_sop ? CRC_INIT : crc_reg;
  assign word_x      = base ^ in_data;
  assign word_fold   = tab0_rdata ^ tab1_rdata ^ tab2_rdata ^ tab3_rdata;
  assign tail_idx    = crc_reg[BYTE_W-1:0] ^ tail_data[BYTE_W-1:0];
  assign tail_fold   = tab0_rdata ^ (crc_reg >> BYTE_W);

  // Next-state, table addressing and register updates
  always_comb begin
    state_d     = state;
    crc_d       = crc_reg;
    tail_data_d = tail_data;
    tail_cnt_d  = tail_cnt;
    crc_valid_d = 1'b0;
    crc_out_d   = crc_out;
    // Word step: byte 0 is the furthest from the end, so it uses the 4-byte table
    tab3_addr   = {PAD_W'(0), word_x[7:0]};
    tab2_addr   = {PAD_W'(0), word_x[15:8]};
    tab1_addr   = {PAD_W'(0), word_x[23:16]};
    tab0_addr   = {PAD_W'(0), word_x[31:24]};

    unique case (state)
      RUN: begin
        if (accept) begin
          if (in_eop && partial_eop) begin
            // Hand the leftover bytes to the tail loop; CRC untouched this edge
            crc_d       = base;
            tail_data_d = in_data[TAIL_W-1:0];
            tail_cnt_d  = CNT_W'(in_nbytes[1:0] - 2'd1);
            state_d     = TAIL;
          end else if (in_eop) begin
            crc_d       = CRC_INIT;
            crc_out_d   = word_fold ^ CRC_XOROUT;
            crc_valid_d = 1'b1;
          end else begin
            crc_d = word_fold;
          end
        end
      end

      TAIL: begin
        tab0_addr   = {PAD_W'(0), tail_idx};
        tab1_addr   = '0;
        tab2_addr   = '0;
        tab3_addr   = '0;
        tail_data_d = tail_data >> BYTE_W;
        if (tail_cnt != '0) begin
          crc_d      = tail_fold;
          tail_cnt_d = tail_cnt - CNT_W'(1);
        end else begin
          crc_out_d   = tail_fold ^ CRC_XOROUT;
          crc_valid_d = 1'b1;
          crc_d       = CRC_INIT;
          state_d     = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_d;
    end
  end

  // CRC, tail and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg   <= CRC_INIT;
      tail_data <= '0;
      tail_cnt  <= '0;
      crc_valid <= 1'b0;
      crc_out   <= '0;
    end else begin
      crc_reg   <= crc_d;
      tail_data <= tail_data_d;
      tail_cnt  <= tail_cnt_d;
      crc_valid <= crc_valid_d;
      crc_out   <= crc_out_d;
    end
  end

endmodule
